// File: rtl/multicycle_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_pkg
//   Shared definitions for the multicycle controller and ALU control:
//   opcode constants, FSM state codes, alu_op / alu_src_b / pc_src encodings
//   and the packed control-word payload produced by the output decoder.
// ----------------------------------------------------------------------------
package multicycle_ctrl_pkg;

  // Default widths
  localparam int unsigned OP_W_DEF    = 6;
  localparam int unsigned STATE_W_DEF = 4;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU control request
  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_ADDI  = 2'b11
  } alu_op_e;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // FSM state codes (13..15 unused)
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_e;

  // Datapath control word
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_e    alu_op;
    logic [1:0] pc_src;
    logic       illegal_op;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_if
//   Controller <-> datapath bundle.
//   master : controller side (consumes opcode/mem_ready, drives controls)
//   slave  : datapath side   (drives opcode/mem_ready, consumes controls)
//   Signals: opcode, mem_ready, pc_write, pc_write_cond, i_or_d, mem_read,
//            mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
//            alu_src_b[1:0], alu_op[1:0], pc_src[1:0], state, illegal_op.
// ----------------------------------------------------------------------------
interface multicycle_ctrl_if
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned OP_W    = OP_W_DEF,
  parameter int unsigned STATE_W = STATE_W_DEF
) ();

  logic [OP_W-1:0]    opcode;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_cond;
  logic               i_or_d;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               mem_to_reg;
  logic               reg_dst;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic [1:0]         pc_src;
  logic [STATE_W-1:0] state;
  logic               illegal_op;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, state, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, state, illegal_op
  );

endinterface

// File: rtl/multicycle_ctrl_outdec.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_outdec
//   Decodes the current FSM state into the datapath control word.
//   Ports:
//     state_i     in   current state
//     mem_ready_i in   memory handshake (only qualifies the fetch writes)
//     ctrl_c      out  control word (combinational)
// ----------------------------------------------------------------------------
module multicycle_ctrl_outdec
  import multicycle_ctrl_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_c
);

  // State -> control word; anything not set stays 0
  always_comb begin
    ctrl_c = CTRL_IDLE;
    case (state_i)
      S_FETCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.alu_src_b = SRCB_FOUR;
        ctrl_c.alu_op    = ALU_ADD;
        ctrl_c.pc_src    = PCSRC_ALU;
        // IR load and PC+4 only commit once the instruction word arrives
        ctrl_c.ir_write  = mem_ready_i;
        ctrl_c.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        // Precompute branch target while the register file is read
        ctrl_c.alu_src_b = SRCB_IMM_SH2;
        ctrl_c.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl_c.mem_read = 1'b1;
        ctrl_c.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.reg_dst    = 1'b0;
      end
      S_MEMWR: begin
        ctrl_c.mem_write = 1'b1;
        ctrl_c.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_REG;
        ctrl_c.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_c.alu_src_a     = 1'b1;
        ctrl_c.alu_src_b     = SRCB_REG;
        ctrl_c.alu_op        = ALU_SUB;
        ctrl_c.pc_write_cond = 1'b1;
        ctrl_c.pc_src        = PCSRC_ALUOUT;
      end
      S_ADDIEX: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALU_ADDI;
      end
      S_ADDIWB: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.reg_dst   = 1'b0;
      end
      S_JUMP: begin
        ctrl_c.pc_write = 1'b1;
        ctrl_c.pc_src   = PCSRC_JUMP;
      end
      S_ILLEGAL: begin
        // State lasts exactly one cycle, so this is a single pulse
        ctrl_c.illegal_op = 1'b1;
      end
      default: ctrl_c = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
//   Moore-style main controller for a multicycle MIPS-subset datapath
//   (R-type, lw, sw, beq, addi, j). Next-state logic lives here; control
//   outputs are decoded from the current state by multicycle_ctrl_outdec.
//   Ports:
//     clk    in      clock, rising edge
//     reset  in      asynchronous active-high reset, returns to FETCH
//     bus    master  opcode/mem_ready in, datapath controls + debug state out
// ----------------------------------------------------------------------------
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned OP_W    = OP_W_DEF,
  parameter int unsigned STATE_W = STATE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);

  state_e          state_q;
  state_e          state_d;
  logic [OP_W-1:0] opcode;
  ctrl_t           ctrl_dec_c;
  ctrl_t           ctrl;

  assign opcode = bus.opcode;

  // Next state; opcode is only looked at in DECODE and MEMADR
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_W'(OP_RTYPE): state_d = S_EXEC;
          OP_W'(OP_LW),
          OP_W'(OP_SW):    state_d = S_MEMADR;
          OP_W'(OP_BEQ):   state_d = S_BRANCH;
          OP_W'(OP_ADDI):  state_d = S_ADDIEX;
          OP_W'(OP_J):     state_d = S_JUMP;
          default:         state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        state_d = (opcode == OP_W'(OP_SW)) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWR: begin
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      // MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, ILLEGAL and unused codes
      default:  state_d = S_FETCH;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  multicycle_ctrl_outdec u_outdec (
    .state_i     (state_q),
    .mem_ready_i (bus.mem_ready),
    .ctrl_c      (ctrl_dec_c)
  );

  // FETCH is the reset state but must not drive its controls while held
  // in reset, so the decoded word is squashed for the duration of reset.
  assign ctrl = reset ? CTRL_IDLE : ctrl_dec_c;

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_src        = ctrl.pc_src;
  assign bus.illegal_op    = ctrl.illegal_op;
  assign bus.state         = STATE_W'(state_q);

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter OP_W, default 6, opcode width in bits.
REQ-002 Parameter STATE_W, default 4, state register width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 opcode  input  OP_W  instruction[31:26] from the instruction register.
REQ-006 mem_ready  input  1  memory access completes this cycle.
REQ-007 pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each  datapath enables/selects.
REQ-008 alu_src_b  output  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-009 alu_op  output  2  to ALU control: 00 add, 01 sub, 10 use funct, 11 addi.
REQ-010 pc_src  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-011 state  output  STATE_W  current state code, for debug.
REQ-012 illegal_op  output  1  one-cycle pulse on unsupported opcode.

Function
REQ-013 Block SHALL be a Moore FSM; all outputs decode from current state only; unlisted outputs are 0.
REQ-014 States/codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, ILLEGAL 12.
REQ-015 FETCH: mem_read=1, ir_write=1, alu_src_b=01, alu_op=00, pc_write=1, pc_src=00; holds while mem_ready=0 with ir_write and pc_write forced 0; on mem_ready=1 -> DECODE.
REQ-016 DECODE: alu_src_b=11, alu_op=00; next by opcode: 000000 -> EXEC, 100011/101011 -> MEMADR, 000100 -> BRANCH, 001000 -> ADDIEX, 000010 -> JUMP, other -> ILLEGAL.
REQ-017 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; lw -> MEMRD, sw -> MEMWR.
REQ-018 MEMRD: mem_read=1, i_or_d=1; hold until mem_ready=1 -> MEMWB.
REQ-019 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
REQ-020 MEMWR: mem_write=1, i_or_d=1; hold until mem_ready=1 -> FETCH.
REQ-021 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB; ALUWB: reg_write=1, reg_dst=1 -> FETCH.
REQ-022 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01 -> FETCH.
REQ-023 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=11 -> ADDIWB; ADDIWB: reg_write=1, reg_dst=0 -> FETCH.
REQ-024 JUMP: pc_write=1, pc_src=10 -> FETCH.
REQ-025 ILLEGAL: illegal_op=1 for exactly one cycle, no writes -> FETCH.
REQ-026 Latency: R-type 4 cycles, lw 5, sw 4, beq 3, addi 4, j 3, each with mem_ready=1 every access; each mem_ready=0 cycle adds one.
REQ-027 mem_write and reg_write SHALL never be 1 in the same cycle; ir_write only in FETCH.
REQ-028 opcode is sampled only in DECODE and MEMADR; changes elsewhere have no effect.

Reset
REQ-029 reset=1 SHALL force state to FETCH asynchronously, at any point including mid-wait in MEMRD/MEMWR.
REQ-030 While reset=1 all outputs SHALL be 0 except state=0; FETCH outputs appear on first cycle after release.
REQ-031 Unused state codes 13-15 SHALL transition to FETCH next cycle with all outputs 0.

Structure
REQ-032 Opcode constants, state codes and alu_op encodings SHALL live in a shared package/header used by this block and ALU control.
REQ-033 One sub-module, multicycle_ctrl_outdec (state -> control outputs), is natural; next-state logic stays in the top.

Verification
REQ-034 Reset released, opcode=000000, mem_ready=1 -> states 0,1,6,7,0; alu_op=10 in EXEC; reg_write=1, reg_dst=1 in ALUWB.
REQ-035 opcode=100011, mem_ready low 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; mem_read and i_or_d held 1 during waits.
REQ-036 opcode=000100 -> states 0,1,8,0; alu_op=01, pc_write_cond=1, pc_src=01 in BRANCH.
REQ-037 opcode=111111 -> states 0,1,12,0; illegal_op high exactly one cycle; no write enables asserted.
REQ-038 reset asserted mid-MEMWR with mem_ready=0 -> state 0 and mem_write 0 immediately, before next clock edge.
REQ-039 opcode=001000 then 000010 -> alu_op=11 in ADDIEX, reg_write in ADDIWB; then pc_write=1, pc_src=10 in JUMP.
